i2c_master_burst: RTL and testbench
===================================

// Module: i2c_master_burst
// PURPOSE
//   Parametrised I2C master: 7-bit addressing, multi-byte write/read bursts,
//   slave-ACK checking, master ACK/NACK on reads, SCL clock stretching.
//   Open-drain style pins (drive-low enables, pad tristates elsewhere).
//   Sits between the system-side controller and the board I2C pads.
// PARAMETERS
//   CLK_DIV   250  clk cycles per SCL quarter-period (SCL = clk/(4*CLK_DIV)); >=2
//   LEN_W     4    width of byte-count field; max burst = 2**LEN_W-1 bytes
// PORTS
//   clk       in   1      system clock, all logic on rising edge
//   reset     in   1      asynchronous, active-low reset
//   start     in   1      1-cycle request; sampled only when busy=0
//   addr      in   7      slave address, latched on accepted start
//   rw        in   1      0=write burst, 1=read burst; latched on start
//   nbytes    in   LEN_W  bytes in burst; 0 = address-only probe
//   wr_data   in   8      next write byte; captured when wr_take=1
//   wr_take   out  1      1-cycle pulse: wr_data captured this cycle
//   rd_data   out  8      last received byte, valid while rd_valid=1
//   rd_valid  out  1      1-cycle pulse per received byte
//   busy      out  1      1 from accepted start until STOP complete
//   done      out  1      1-cycle pulse when transaction ends (ok or error)
//   ack_err   out  1      sticky NACK flag; cleared on next accepted start
//   scl_oe    out  1      1 = pull SCL low
//   sda_oe    out  1      1 = pull SDA low
//   scl_i     in   1      SCL pad level (stretch detect)
//   sda_i     in   1      SDA pad level (ACK/read sampling)
// BEHAVIOUR
//   Reset (reset=0): state IDLE, scl_oe=0, sda_oe=0, busy=0, done=0,
//     wr_take=0, rd_valid=0, rd_data=0, ack_err=0, divider and counters 0.
//     Mid-transaction reset releases both lines immediately; no STOP issued.
//   Tick: divider counts 0..CLK_DIV-1; tick at wrap. Each bit = 4 ticks
//     (phase0 SCL low/SDA change, phase1 release SCL, phase2 SCL high/sample,
//     phase3 pull SCL low). Divider held reset in IDLE.
//   Stretch: in phase1->2, if scl_i=0 after release, divider frozen until
//     scl_i=1; no timeout.
//   States: IDLE -> START -> ADDR(8 bits: addr,rw MSB first) -> ADDR_ACK
//     -> WRITE/READ per rw (or STOP if nbytes=0) -> WR_ACK/RD_ACK -> loop
//     while bytes remain -> STOP -> IDLE.
//   START: SDA low while SCL high, then SCL low. STOP: SDA low, SCL released,
//     then SDA released; done pulses the cycle state returns to IDLE.
//   start with busy=1: ignored, no latch. busy rises cycle after start.
//   Write: wr_take pulses at entry to each WRITE byte; nbytes pulses total.
//   ACK sample: sda_i at phase2 of ACK bit; sda_i=1 -> ack_err=1, skip
//     remaining bytes, go STOP. Address NACK -> no wr_take/rd_valid.
//   Read: sda released 8 bits, shifted MSB first at phase2; rd_data/rd_valid
//     updated at end of bit 8. Master drives ACK (sda_oe=1) except on last
//     byte: NACK (sda_oe=0), then STOP.
//   Byte counter LEN_W wide, loaded from nbytes, decremented per byte; no wrap.
// TESTING  (CLK_DIV=4, LEN_W=4)
//   Reset low 3 cycles mid-WRITE -> scl_oe=sda_oe=0, busy=0 same/next edge.
//   Write addr=0x50 nbytes=2 wr_data=0xAB,0xCD, slave ACKs -> SDA bits
//     0xA0,0xAB,0xCD; 2 wr_take; done, ack_err=0; 27 bits + START/STOP.
//   Read addr=0x68 nbytes=3, slave sends 0x11,0x22,0x33 -> 3 rd_valid pulses
//     with those values; master ACK,ACK,NACK; STOP; done.
//   Address NACK (sda_i=1 at ACK) -> ack_err=1, STOP, done, no wr_take.
//   nbytes=0 probe addr=0x3C -> START, 0x78, ACK, STOP; done, no data pulses.
//   Slave holds scl_i=0 20 cycles in byte 1 -> bit period stretched by 20
//     cycles, data intact; start pulsed while busy -> ignored.

Source files
------------

// File: rtl/i2c_master_burst.sv
// i2c_master_burst: 7-bit-address I2C master with multi-byte write/read bursts,
// slave ACK checking, master ACK/NACK on reads and SCL clock stretching.
module i2c_master_burst #(
    parameter int CLK_DIV = 250,
    parameter int LEN_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [6:0]       addr,
    input  logic             rw,
    input  logic [LEN_W-1:0] nbytes,
    input  logic [7:0]       wr_data,
    output logic             wr_take,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             done,
    output logic             ack_err,
    output logic             scl_oe,
    output logic             sda_oe,
    input  logic             scl_i,
    input  logic             sda_i
);
    localparam int DW = $clog2(CLK_DIV);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WRITE, S_WR_ACK, S_READ, S_RD_ACK, S_STOP
    } state_t;

    state_t           r_state, w_next;
    logic [DW-1:0]    r_div;
    logic [1:0]       r_ph;
    logic [2:0]       r_bit;
    logic [7:0]       r_sh;
    logic [LEN_W-1:0] r_cnt;
    logic             r_rw, r_rd_valid, r_done, r_ack_err;
    logic [7:0]       r_rd_data;
    logic             w_freeze, w_tick, w_end, w_smp, w_last, w_load, w_byte, w_bitst;

    // SCL released but still held low by a slave: freeze the bit timing
    assign w_freeze = (r_ph == 2'd1) && !scl_i;
    assign w_tick   = (r_state != S_IDLE) && !w_freeze && (r_div == DW'(CLK_DIV - 1));
    assign w_end    = w_tick && (r_ph == 2'd3);
    assign w_smp    = w_tick && (r_ph == 2'd2);
    assign w_last   = r_bit == 3'd7;
    assign w_byte   = (r_state == S_ADDR) || (r_state == S_WRITE) || (r_state == S_READ);
    assign w_bitst  = w_byte || (r_state == S_ADDR_ACK) || (r_state == S_WR_ACK) || (r_state == S_RD_ACK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            S_IDLE:     if (start) w_next = S_START;
            S_START:    if (w_end) w_next = S_ADDR;
            S_ADDR:     if (w_end && w_last) w_next = S_ADDR_ACK;
            S_ADDR_ACK,
            S_WR_ACK:   if (w_end) begin
                            if (r_ack_err || r_cnt == '0) w_next = S_STOP;
                            else if (r_rw) w_next = S_READ;
                            else begin
                                w_next = S_WRITE;
                                w_load = 1'b1;
                            end
                        end
            S_WRITE:    if (w_end && w_last) w_next = S_WR_ACK;
            S_READ:     if (w_end && w_last) w_next = S_RD_ACK;
            S_RD_ACK:   if (w_end) w_next = (r_cnt == '0) ? S_STOP : S_READ;
            S_STOP:     if (w_end) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div      <= '0;
            r_ph       <= '0;
            r_bit      <= '0;
            r_sh       <= '0;
            r_cnt      <= '0;
            r_rw       <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_ack_err  <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            if (r_state == S_IDLE) begin
                r_div <= '0;
                r_ph  <= '0;
            end else if (!w_freeze) begin
                r_div <= w_tick ? '0 : r_div + 1'b1;
                if (w_tick) r_ph <= r_ph + 2'd1;
            end
            if (r_state == S_IDLE && start) begin
                r_sh      <= {addr, rw};
                r_rw      <= rw;
                r_cnt     <= nbytes;
                r_ack_err <= 1'b0;
                r_bit     <= '0;
            end
            if (w_smp && (r_state == S_ADDR_ACK || r_state == S_WR_ACK) && sda_i) r_ack_err <= 1'b1;
            if (w_smp && r_state == S_READ) r_sh <= {r_sh[6:0], sda_i};
            if (w_end) begin
                r_bit <= (w_byte && !w_last) ? r_bit + 3'd1 : 3'd0;
                if (r_state == S_ADDR || r_state == S_WRITE) r_sh <= {r_sh[6:0], 1'b0};
                if ((r_state == S_WRITE || r_state == S_READ) && w_last && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                if (r_state == S_READ && w_last) begin
                    r_rd_data  <= r_sh;
                    r_rd_valid <= 1'b1;
                end
                if (r_state == S_STOP) r_done <= 1'b1;
            end
            if (w_load) r_sh <= wr_data;
        end
    end

    // START: SDA falls in phase 2 with SCL high; STOP: SDA rises in phase 3 with SCL high
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (r_state)
            S_START:          begin scl_oe = r_ph == 2'd3; sda_oe = r_ph[1]; end
            S_STOP:           begin scl_oe = r_ph == 2'd0; sda_oe = r_ph != 2'd3; end
            S_ADDR, S_WRITE:  begin scl_oe = r_ph == 2'd0 || r_ph == 2'd3; sda_oe = !r_sh[7]; end
            S_RD_ACK:         begin scl_oe = r_ph == 2'd0 || r_ph == 2'd3; sda_oe = r_cnt != '0; end
            default:          scl_oe = w_bitst && (r_ph == 2'd0 || r_ph == 2'd3);
        endcase
    end

    assign wr_take  = w_load;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign busy     = r_state != S_IDLE;
    assign done     = r_done;
    assign ack_err  = r_ack_err;
endmodule

// File: tb/tb_i2c_master_burst.sv
// tb_i2c_master_burst: directed bench with a behavioural open-drain slave that
// decodes START/STOP, captures every SCL-sampled bit and answers ACK/read data.
module tb_i2c_master_burst;
    logic       clk = 1'b0, reset = 1'b1, start = 1'b0, rw = 1'b0;
    logic [6:0] addr = '0;
    logic [3:0] nbytes = '0;
    logic [7:0] wr_data;
    logic       wr_take, rd_valid, busy, done, ack_err, scl_oe, sda_oe;
    logic [7:0] rd_data;
    logic       stretch = 1'b0, sl_sda = 1'b1;
    wire        scl_line = ~scl_oe & ~stretch;
    wire        sda_line = ~sda_oe & sl_sda;

    int checks = 0, errors = 0;
    logic       ack_addr = 1'b1, ack_data = 1'b1, rd_mode = 1'b0, clr_tog = 1'b0;
    logic [7:0] wr_tab [0:3];
    logic [7:0] rd_bytes [0:3];
    int         nrd = 0;

    i2c_master_burst #(.CLK_DIV(4), .LEN_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .rw(rw), .nbytes(nbytes),
        .wr_data(wr_data), .wr_take(wr_take), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .done(done), .ack_err(ack_err), .scl_oe(scl_oe), .sda_oe(sda_oe),
        .scl_i(scl_line), .sda_i(sda_line)
    );

    always #5 clk = ~clk;

    // Bus-side slave model
    int         rise_cnt = 0, start_cnt = 0, stop_cnt = 0, bits = 0, b, p;
    logic [7:0] sh = '0;
    logic [7:0] cap_bytes [0:7];
    logic       cap_ack [0:7];
    logic       p_scl = 1'b1, p_sda = 1'b1, p_tog = 1'b0;
    always @(scl_line, sda_line, clr_tog) begin
        if (clr_tog != p_tog) begin
            rise_cnt = 0; start_cnt = 0; stop_cnt = 0; bits = 0; sl_sda = 1'b1; sh = '0;
            for (int i = 0; i < 8; i++) begin cap_bytes[i] = '0; cap_ack[i] = 1'b0; end
        end else if (scl_line && p_scl && p_sda && !sda_line) begin
            start_cnt++; rise_cnt = 0;
        end else if (scl_line && p_scl && !p_sda && sda_line) begin
            stop_cnt++; bits = rise_cnt - 1;
        end else if (scl_line && !p_scl) begin
            sh = {sh[6:0], sda_line};
            if (rise_cnt / 9 < 8 && rise_cnt % 9 == 7) cap_bytes[rise_cnt / 9] = sh;
            if (rise_cnt / 9 < 8 && rise_cnt % 9 == 8) cap_ack[rise_cnt / 9] = sda_line;
            rise_cnt++;
        end else if (!scl_line && p_scl) begin
            b = rise_cnt / 9; p = rise_cnt % 9;
            if (p == 8) sl_sda = (b == 0) ? !ack_addr : (rd_mode ? 1'b1 : !ack_data);
            else sl_sda = (rd_mode && b >= 1 && b <= nrd) ? rd_bytes[b-1][7-p] : 1'b1;
        end
        p_scl = scl_line; p_sda = sda_line; p_tog = clr_tog;
    end

    // System-side monitor and write-data supplier
    int         take_cnt = 0, take_idx = 0, rd_cnt = 0, done_cnt = 0;
    logic       pend = 1'b0, q_tog = 1'b0;
    logic [7:0] rd_vals [0:3];
    always @(negedge clk) begin
        if (clr_tog != q_tog) begin
            take_cnt = 0; take_idx = 0; pend = 1'b0; rd_cnt = 0; done_cnt = 0; q_tog = clr_tog;
        end else begin
            if (wr_take) begin take_cnt++; pend = 1'b1; end
            else if (pend) begin take_idx++; pend = 1'b0; end
            if (rd_valid) begin if (rd_cnt < 4) rd_vals[rd_cnt] = rd_data; rd_cnt++; end
            if (done) done_cnt++;
        end
        wr_data = wr_tab[take_idx % 4];
    end

    time t_prev = 0, t_last = 0;
    always @(negedge scl_oe) begin t_prev = t_last; t_last = $time; end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [6:0] a, input logic r, input logic [3:0] n);
        clr_tog = ~clr_tog;
        @(negedge clk);
        addr = a; rw = r; nbytes = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 3000) begin @(negedge clk); n++; end
        chk(tag, done, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic wait_rise(input int target);
        int n = 0;
        while (rise_cnt < target && n < 3000) begin @(negedge clk); n++; end
        chk("rise_reached", rise_cnt >= target, 1'b1);
    endtask

    initial begin
        wr_tab[0] = 8'hAB; wr_tab[1] = 8'hCD; wr_tab[2] = 8'h00; wr_tab[3] = 8'h00;
        rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; rd_bytes[2] = 8'h33; rd_bytes[3] = 8'h00;
        #2 reset = 1'b0;
        #1;
        chk("rst_scl", scl_oe, 0); chk("rst_sda", sda_oe, 0); chk("rst_busy", busy, 0);
        chk("rst_done", done, 0); chk("rst_take", wr_take, 0); chk("rst_rdv", rd_valid, 0);
        chk("rst_rdd", rd_data, 0); chk("rst_err", ack_err, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Reset asserted in the middle of the first data byte
        go(7'h50, 1'b0, 4'd2);
        chk("busy_rise", busy, 1);
        wait_rise(12);
        reset = 1'b0;
        #1;
        chk("mid_scl", scl_oe, 0); chk("mid_sda", sda_oe, 0); chk("mid_busy", busy, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_done", done, 0); chk("mid_busy2", busy, 0);

        // Two-byte write
        go(7'h50, 1'b0, 4'd2);
        wait_done("wr_done");
        chk("wr_err", ack_err, 0);
        repeat (4) @(negedge clk);
        chk("wr_b0", cap_bytes[0], 8'hA0); chk("wr_b1", cap_bytes[1], 8'hAB);
        chk("wr_b2", cap_bytes[2], 8'hCD); chk("wr_bits", bits, 27);
        chk("wr_takes", take_cnt, 2); chk("wr_ack2", cap_ack[2], 0);
        chk("wr_start", start_cnt, 1); chk("wr_stop", stop_cnt, 1); chk("wr_dcnt", done_cnt, 1);

        // Three-byte read
        rd_mode = 1'b1; nrd = 3;
        go(7'h68, 1'b1, 4'd3);
        wait_done("rd_done");
        repeat (4) @(negedge clk);
        chk("rd_addr", cap_bytes[0], 8'hD1); chk("rd_cnt", rd_cnt, 3);
        chk("rd_v0", rd_vals[0], 8'h11); chk("rd_v1", rd_vals[1], 8'h22); chk("rd_v2", rd_vals[2], 8'h33);
        chk("rd_m0", cap_ack[1], 0); chk("rd_m1", cap_ack[2], 0); chk("rd_m2", cap_ack[3], 1);
        chk("rd_bits", bits, 36); chk("rd_stop", stop_cnt, 1); chk("rd_data_hold", rd_data, 8'h33);
        chk("rd_takes", take_cnt, 0); chk("rd_err", ack_err, 0);
        rd_mode = 1'b0; nrd = 0;

        // Address NACK
        ack_addr = 1'b0;
        go(7'h50, 1'b0, 4'd2);
        wait_done("nack_done");
        chk("nack_err", ack_err, 1);
        repeat (4) @(negedge clk);
        chk("nack_takes", take_cnt, 0); chk("nack_bits", bits, 9);
        chk("nack_stop", stop_cnt, 1); chk("nack_ack", cap_ack[0], 1); chk("nack_sticky", ack_err, 1);
        ack_addr = 1'b1;

        // Address-only probe
        go(7'h3C, 1'b0, 4'd0);
        chk("probe_clr", ack_err, 0);
        wait_done("probe_done");
        repeat (4) @(negedge clk);
        chk("probe_addr", cap_bytes[0], 8'h78); chk("probe_bits", bits, 9);
        chk("probe_ack", cap_ack[0], 0); chk("probe_takes", take_cnt, 0);
        chk("probe_rd", rd_cnt, 0); chk("probe_stop", stop_cnt, 1); chk("probe_err", ack_err, 0);

        // Clock stretch of 20 cycles on address bit 2, plus start while busy
        wr_tab[0] = 8'h5A;
        go(7'h50, 1'b0, 4'd1);
        begin
            int n = 0;
            while (!(rise_cnt == 2 && !scl_line) && n < 3000) begin @(negedge clk); n++; end
            chk("st_pos", rise_cnt, 2);
            stretch = 1'b1;
            n = 0;
            while (scl_oe && n < 100) begin @(negedge clk); n++; end
            chk("st_rel", scl_oe, 0);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = (i == 0);
            if (i == 0) begin addr = 7'h11; rw = 1'b1; nbytes = 4'd5; end
        end
        stretch = 1'b0;
        wait_rise(4);
        chk("st_period", 32'(t_last - t_prev), 360);
        wait_done("st_done");
        repeat (4) @(negedge clk);
        chk("st_b0", cap_bytes[0], 8'hA0); chk("st_b1", cap_bytes[1], 8'h5A);
        chk("st_bits", bits, 18); chk("st_takes", take_cnt, 1); chk("st_starts", start_cnt, 1);
        repeat (30) @(negedge clk);
        chk("st_idle", busy, 0); chk("st_dcnt", done_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
